// File: rtl/cpu_boot_loader_pkg.sv
// Shared definitions for the boot loader: state encoding and instruction width.
package cpu_boot_loader_pkg;

    localparam int INSTR_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HI    = 3'd1,
        ST_LO    = 3'd2,
        ST_CSUM  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_RUN   = 3'd5,
        ST_ERROR = 3'd6
    } boot_state_t;

    // Only the frame-parsing states take bytes off the link.
    function automatic logic accepts_byte(boot_state_t s);
        return (s == ST_IDLE) || (s == ST_HI) || (s == ST_LO) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/cpu_boot_loader_if.sv
// Byte link into the loader plus the instruction-memory write port out of it.
interface cpu_boot_loader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [DATA_W-1:0] im_wdata;

    modport master (output rx_valid, rx_data, input rx_ready, im_we, im_addr, im_wdata);
    modport slave  (input rx_valid, rx_data, output rx_ready, im_we, im_addr, im_wdata);
endinterface

// File: rtl/cpu_boot_hold_timer.sv
// 4-bit load/decrement counter; done flags the last cycle of the hold window.
module cpu_boot_hold_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       done
);
    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign done = (cnt == 4'd1);
endmodule

// File: rtl/cpu_boot_loader.sv
// Program-load front end: parses COUNT/words/CSUM frames into instruction memory
// and releases the core's reset only after the checksum matches.
module cpu_boot_loader
    import cpu_boot_loader_pkg::*;
#(
    parameter int DATA_W   = INSTR_W,
    parameter int ADDR_W   = 8,
    parameter int RST_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    cpu_boot_loader_if.slave  bus,
    output logic              cpu_rst,
    output logic              boot_done,
    output logic              err
);
    boot_state_t       state;
    logic [7:0]        hi_byte;
    logic [7:0]        chk_acc;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [ADDR_W-1:0] words;
    logic [DATA_W-1:0] word_nxt;
    logic              xfer;
    logic              timer_load;
    logic              timer_done;

    assign bus.rx_ready = accepts_byte(state);
    assign xfer         = bus.rx_valid && bus.rx_ready;
    assign addr_nxt     = addr_cnt + 1'b1;
    assign word_nxt     = {hi_byte, bus.rx_data};
    assign timer_load   = xfer && (state == ST_CSUM) && (bus.rx_data == chk_acc);

    cpu_boot_hold_timer u_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (4'(RST_HOLD)),
        .dec      (state == ST_HOLD),
        .done     (timer_done)
    );

    always_ff @(posedge clk) begin
        if (xfer && state == ST_HI) begin
            hi_byte <= bus.rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cpu_rst      <= 1'b1;
            boot_done    <= 1'b0;
            err          <= 1'b0;
            bus.im_we    <= 1'b0;
            bus.im_addr  <= '0;
            bus.im_wdata <= '0;
            addr_cnt     <= '0;
            words        <= '0;
            chk_acc      <= 8'h00;
        end else begin
            bus.im_we <= 1'b0;
            case (state)
                ST_IDLE: if (xfer) begin
                    // COUNT of 0 wraps naturally: the last word is the one whose
                    // incremented address returns to 0.
                    words    <= bus.rx_data[ADDR_W-1:0];
                    chk_acc  <= 8'h00;
                    addr_cnt <= '0;
                    state    <= ST_HI;
                end
                ST_HI: if (xfer) begin
                    chk_acc <= chk_acc ^ bus.rx_data;
                    state   <= ST_LO;
                end
                ST_LO: if (xfer) begin
                    chk_acc      <= chk_acc ^ bus.rx_data;
                    bus.im_we    <= 1'b1;
                    bus.im_addr  <= addr_cnt;
                    bus.im_wdata <= word_nxt;
                    addr_cnt     <= addr_nxt;
                    state        <= (addr_nxt == words) ? ST_CSUM : ST_HI;
                end
                ST_CSUM: if (xfer) begin
                    if (bus.rx_data == chk_acc) begin
                        state <= ST_HOLD;
                    end else begin
                        state <= ST_ERROR;
                        err   <= 1'b1;
                    end
                end
                ST_HOLD: if (timer_done) begin
                    state     <= ST_RUN;
                    cpu_rst   <= 1'b0;
                    boot_done <= 1'b1;
                end
                ST_RUN, ST_ERROR: state <= state;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_boot_loader.sv
// Directed bench for cpu_boot_loader with a frame-level reference model.
module tb_cpu_boot_loader;
    localparam int ADDR_W   = 3;
    localparam int RST_HOLD = 4;
    localparam int NW       = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cpu_rst, boot_done, err;

    always #5 clk = ~clk;

    cpu_boot_loader_if #(.DATA_W(16), .ADDR_W(ADDR_W)) tb_if ();

    cpu_boot_loader #(.DATA_W(16), .ADDR_W(ADDR_W), .RST_HOLD(RST_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (tb_if),
        .cpu_rst   (cpu_rst),
        .boot_done (boot_done),
        .err       (err)
    );

    int vec  = 0;
    int miss = 0;
    int cyc  = 0;
    bit started = 0;

    // Reference model state: byte position within the frame and expected outputs.
    int          m_pos, m_words, m_widx, m_rel;
    logic [7:0]  m_chk, m_hi;
    logic        m_ready, m_we, m_cpu_rst, m_boot, m_err;
    logic [ADDR_W-1:0] m_addr;
    logic [15:0] m_wdata;

    int          wl_addr[$];
    int          wl_data[$];
    int          wl_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin : model
        logic [7:0] b;
        cyc++;
        if (rst) begin
            started   = 1;
            m_pos     = 0;
            m_ready   = 1;
            m_we      = 0;
            m_addr    = '0;
            m_wdata   = 16'h0;
            m_cpu_rst = 1;
            m_boot    = 0;
            m_err     = 0;
            m_rel     = -1;
        end else begin
            m_we = 0;
            if (m_ready && tb_if.rx_valid) begin
                b = tb_if.rx_data;
                if (m_pos == 0) begin
                    m_words = (b % NW == 0) ? NW : b % NW;
                    m_chk   = 8'h00;
                    m_widx  = 0;
                end else if (m_pos <= 2 * m_words) begin
                    m_chk = m_chk ^ b;
                    if (m_pos % 2 == 1) begin
                        m_hi = b;
                    end else begin
                        m_we    = 1;
                        m_addr  = ADDR_W'(m_widx % NW);
                        m_wdata = {m_hi, b};
                        m_widx++;
                    end
                end else begin
                    m_ready = 0;
                    if (b == m_chk) m_rel = cyc + RST_HOLD;
                    else m_err = 1;
                end
                m_pos++;
            end
            if (cyc == m_rel) begin
                m_cpu_rst = 0;
                m_boot    = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("rx_ready", 32'(tb_if.rx_ready), 32'(m_ready));
            chk("im_we", 32'(tb_if.im_we), 32'(m_we));
            chk("im_addr", 32'(tb_if.im_addr), 32'(m_addr));
            chk("im_wdata", 32'(tb_if.im_wdata), 32'(m_wdata));
            chk("cpu_rst", 32'(cpu_rst), 32'(m_cpu_rst));
            chk("boot_done", 32'(boot_done), 32'(m_boot));
            chk("err", 32'(err), 32'(m_err));
            chk("done_err_excl", 32'(boot_done & err), 32'd0);
            if (tb_if.im_we) begin
                wl_addr.push_back(int'(tb_if.im_addr));
                wl_data.push_back(int'(tb_if.im_wdata));
                wl_cyc.push_back(cyc);
            end
        end
    end

    task automatic clear_log();
        wl_addr.delete();
        wl_data.delete();
        wl_cyc.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int  n;
        logic acc;
        n = 0;
        tb_if.rx_valid = 1'b1;
        tb_if.rx_data  = b;
        do begin
            acc = tb_if.rx_ready;
            @(negedge clk);
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            vec++;
            miss++;
            $display("FAIL send_byte: byte 0x%0h not accepted within %0d cycles", b, n);
        end
        tb_if.rx_valid = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Measured as the number of posedges until the core first samples cpu_rst low.
    task automatic wait_release(input int tcsum);
        int n;
        n = 0;
        while (cpu_rst !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("release_delay", 32'(cyc - tcsum + 1), 32'd5);
    endtask

    task automatic check_write(input int idx, input int addr, input int data);
        if (idx < wl_addr.size()) begin
            chk("wr_addr", 32'(wl_addr[idx]), 32'(addr));
            chk("wr_data", 32'(wl_data[idx]), 32'(data));
        end else begin
            chk("wr_missing", 32'(wl_addr.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        int tcsum;
        logic [7:0] frame1 [8];
        frame1 = '{8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h0F, 8'h0F, 8'h40};
        tb_if.rx_valid = 1'b0;
        tb_if.rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_boot_done", 32'(boot_done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_im_we", 32'(tb_if.im_we), 32'd0);
        chk("rst_rx_ready", 32'(tb_if.rx_ready), 32'd1);

        // Test 1: three words; checksum 12^34^AB^CD^0F^0F = 0x40
        clear_log();
        for (int i = 0; i < 8; i++) send_byte(frame1[i]);
        tcsum = cyc;
        chk("t1_model_chk", 32'(m_chk), 32'h40);
        wait_release(tcsum);
        chk("t1_nwrites", 32'(wl_addr.size()), 32'd3);
        check_write(0, 0, 16'h1234);
        check_write(1, 1, 16'hABCD);
        check_write(2, 2, 16'h0F0F);
        chk("t1_boot_done", 32'(boot_done), 32'd1);
        chk("t1_err", 32'(err), 32'd0);

        // Test 2: wrong checksum
        pulse_rst();
        clear_log();
        for (int i = 0; i < 7; i++) send_byte(frame1[i]);
        send_byte(8'h00);
        chk("t2_err_next", 32'(err), 32'd1);
        chk("t2_ready", 32'(tb_if.rx_ready), 32'd0);
        tb_if.rx_valid = 1'b1;
        tb_if.rx_data  = 8'h40;
        repeat (20) @(negedge clk);
        tb_if.rx_valid = 1'b0;
        chk("t2_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("t2_boot_done", 32'(boot_done), 32'd0);
        chk("t2_nwrites", 32'(wl_addr.size()), 32'd3);

        // Test 3: rx_valid toggling every cycle
        pulse_rst();
        clear_log();
        for (int i = 0; i < 7; i++) begin
            send_byte(frame1[i]);
            @(negedge clk);
        end
        send_byte(frame1[7]);
        tcsum = cyc;
        wait_release(tcsum);
        chk("t3_nwrites", 32'(wl_addr.size()), 32'd3);
        check_write(0, 0, 16'h1234);
        check_write(1, 1, 16'hABCD);
        check_write(2, 2, 16'h0F0F);
        if (wl_cyc.size() == 3) begin
            chk("t3_spacing01", 32'(wl_cyc[1] - wl_cyc[0]), 32'd4);
            chk("t3_spacing12", 32'(wl_cyc[2] - wl_cyc[1]), 32'd4);
        end

        // Test 4: reset mid-load, then a 1-word frame
        pulse_rst();
        for (int i = 0; i < 4; i++) send_byte(frame1[i]);
        pulse_rst();
        chk("t4_im_we", 32'(tb_if.im_we), 32'd0);
        chk("t4_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("t4_ready", 32'(tb_if.rx_ready), 32'd1);
        clear_log();
        send_byte(8'h01);
        send_byte(8'hBE);
        send_byte(8'hEF);
        send_byte(8'h51);
        tcsum = cyc;
        wait_release(tcsum);
        chk("t4_nwrites", 32'(wl_addr.size()), 32'd1);
        check_write(0, 0, 16'hBEEF);

        // Test 5: COUNT=0 means a full 8-word image
        pulse_rst();
        clear_log();
        send_byte(8'h00);
        for (int i = 0; i < 8; i++) begin
            send_byte(8'h00);
            send_byte(8'(i));
        end
        send_byte(8'h00);
        tcsum = cyc;
        wait_release(tcsum);
        repeat (4) @(negedge clk);
        chk("t5_nwrites", 32'(wl_addr.size()), 32'd8);
        for (int i = 0; i < 8; i++) check_write(i, i, i);

        // Test 6: rst wins over a COUNT byte in the same cycle
        rst = 1'b1;
        tb_if.rx_valid = 1'b1;
        tb_if.rx_data  = 8'h02;
        @(negedge clk);
        rst = 1'b0;
        clear_log();
        send_byte(8'h01);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h26);
        tcsum = cyc;
        wait_release(tcsum);
        chk("t6_nwrites", 32'(wl_addr.size()), 32'd1);
        check_write(0, 0, 16'h1234);
        chk("t6_boot_done", 32'(boot_done), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d miscompares=%0d", vec, miss);
        $fatal(1, "watchdog expired");
    end
endmodule
